multi_adder_with_flow_control: RTL and testbench

//  N-input adder with valid/ready flow control on every input and on the output.

---
 rtl/multi_adder_with_flow_control_if.sv | 30 +++
 rtl/multi_adder_with_flow_control.sv | 121 ++++++++++++
 tb/tb_multi_adder_with_flow_control.sv | 247 ++++++++++++++++++++++++
 3 files changed

// File: rtl/multi_adder_with_flow_control_if.sv
`default_nettype none
// ============================================================================
//  Module   : multi_adder_with_flow_control_if
//  Brief    : Handshake bundle for the N-input adder: per-channel inputs and
//             the single summed output stream.
//  Revision : 1.0  initial release
// ============================================================================
interface multi_adder_with_flow_control_if #(
    parameter int WIDTH = 8,
    parameter int N_IN  = 4,
    parameter int SW    = WIDTH + $clog2(N_IN)
);
    logic [N_IN-1:0]       in_vld;
    logic [N_IN-1:0]       in_rdy;
    logic [N_IN*WIDTH-1:0] in_data;
    logic                  sum_vld;
    logic                  sum_rdy;
    logic [SW-1:0]         sum_data;

    modport master (
        output in_vld, in_data, sum_rdy,
        input  in_rdy, sum_vld, sum_data
    );

    modport slave (
        input  in_vld, in_data, sum_rdy,
        output in_rdy, sum_vld, sum_data
    );
endinterface
`default_nettype wire

// File: rtl/multi_adder_with_flow_control.sv
`default_nettype none
// ============================================================================
//  Module   : multi_adder_with_flow_control
//  Brief    : N-input adder; 2-entry skid buffer per channel, join stage that
//             adds one item from every channel, output FIFO of OUT_DEPTH sums.
//  Revision : 1.0  initial release
// ============================================================================
module multi_adder_with_flow_control #(
    parameter int WIDTH     = 8,
    parameter int N_IN      = 4,
    parameter int OUT_DEPTH = 2,
    parameter int SIGNED    = 0
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    multi_adder_with_flow_control_if.slave bus
);
    localparam int SW = WIDTH + $clog2(N_IN);
    localparam int AW = $clog2(OUT_DEPTH);

    logic [N_IN-1:0]  w_push;
    logic [N_IN-1:0]  w_skid_nonempty;
    logic [N_IN-1:0]  w_in_rdy;
    logic [WIDTH-1:0] w_head [N_IN];
    logic             w_fire;
    logic             w_pop;
    logic             w_fifo_full;
    logic             w_fifo_empty;
    logic [SW-1:0]    w_sum;

    logic [SW-1:0]    r_fifo [OUT_DEPTH];
    logic [AW:0]      r_fifo_wp;
    logic [AW:0]      r_fifo_rp;

    for (genvar i = 0; i < N_IN; i++) begin : g_ch
        logic [WIDTH-1:0] r_mem [2];
        logic             r_wp;
        logic             r_rp;
        logic [1:0]       r_cnt;
        logic             r_rdy;
        logic [1:0]       w_cnt_nxt;

        assign w_push[i]          = bus.in_vld[i] & r_rdy;
        assign w_skid_nonempty[i] = (r_cnt != 2'd0);
        assign w_head[i]          = r_mem[r_rp];
        assign w_in_rdy[i]        = r_rdy;

        always_comb begin
            w_cnt_nxt = r_cnt;
            if (w_push[i] && !w_fire) begin
                w_cnt_nxt = r_cnt + 2'd1;
            end else if (!w_push[i] && w_fire) begin
                w_cnt_nxt = r_cnt - 2'd1;
            end
        end

        // Ready is a pure register: looks one cycle ahead at the next count.
        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                r_mem[0] <= '0;
                r_mem[1] <= '0;
                r_wp     <= 1'b0;
                r_rp     <= 1'b0;
                r_cnt    <= 2'd0;
                r_rdy    <= 1'b0;
            end else begin
                if (w_push[i]) begin
                    r_mem[r_wp] <= bus.in_data[i*WIDTH +: WIDTH];
                    r_wp        <= ~r_wp;
                end
                if (w_fire) begin
                    r_rp <= ~r_rp;
                end
                r_cnt <= w_cnt_nxt;
                r_rdy <= (w_cnt_nxt != 2'd2);
            end
        end
    end

    always_comb begin
        w_sum = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (SIGNED != 0) begin
                w_sum = w_sum + {{(SW-WIDTH){w_head[i][WIDTH-1]}}, w_head[i]};
            end else begin
                w_sum = w_sum + {{(SW-WIDTH){1'b0}}, w_head[i]};
            end
        end
    end

    assign w_fifo_empty = (r_fifo_wp == r_fifo_rp);
    assign w_fifo_full  = (r_fifo_wp[AW] != r_fifo_rp[AW]) &&
                          (r_fifo_wp[AW-1:0] == r_fifo_rp[AW-1:0]);
    assign w_pop        = !w_fifo_empty && bus.sum_rdy;
    // A pop in the same cycle frees the slot the join is about to fill.
    assign w_fire       = (&w_skid_nonempty) && (!w_fifo_full || w_pop);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 0; k < OUT_DEPTH; k++) begin
                r_fifo[k] <= '0;
            end
            r_fifo_wp <= '0;
            r_fifo_rp <= '0;
        end else begin
            if (w_fire) begin
                r_fifo[r_fifo_wp[AW-1:0]] <= w_sum;
                r_fifo_wp                 <= r_fifo_wp + 1'b1;
            end
            if (w_pop) begin
                r_fifo_rp <= r_fifo_rp + 1'b1;
            end
        end
    end

    assign bus.in_rdy   = w_in_rdy;
    assign bus.sum_vld  = !w_fifo_empty;
    assign bus.sum_data = w_fifo_empty ? '0 : r_fifo[r_fifo_rp[AW-1:0]];

endmodule
`default_nettype wire

// File: tb/tb_multi_adder_with_flow_control.sv
`default_nettype none
// ============================================================================
//  Module   : tb_multi_adder_with_flow_control
//  Brief    : Directed and random stimulus against a sequence-level model:
//             the k-th sum is the sum of every channel's k-th accepted item.
//  Revision : 1.0  initial release
// ============================================================================
module tb_multi_adder_with_flow_control;
    localparam int WIDTH     = 8;
    localparam int N_IN      = 4;
    localparam int OUT_DEPTH = 2;
    localparam int SW        = WIDTH + $clog2(N_IN);
    localparam int HMAX      = 8192;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    multi_adder_with_flow_control_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus ();
    multi_adder_with_flow_control_if #(.WIDTH(WIDTH), .N_IN(N_IN)) bus_s ();

    multi_adder_with_flow_control #(
        .WIDTH(WIDTH), .N_IN(N_IN), .OUT_DEPTH(OUT_DEPTH), .SIGNED(0)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    multi_adder_with_flow_control #(
        .WIDTH(WIDTH), .N_IN(N_IN), .OUT_DEPTH(OUT_DEPTH), .SIGNED(1)
    ) dut_s (
        .clk (clk),
        .rst (rst),
        .bus (bus_s)
    );

    int errors = 0;
    int checks = 0;

    // Model: history of accepted items per channel, one shared read index.
    logic [WIDTH-1:0] hist [N_IN][HMAX];
    int               wr_n [N_IN];
    int               rd_n;
    int               n_out;
    logic [N_IN-1:0]  last_acc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int min_wr();
        int m = wr_n[0];
        for (int c = 1; c < N_IN; c++) if (wr_n[c] < m) m = wr_n[c];
        return m;
    endfunction

    function automatic int exp_sum(input int k);
        int s = 0;
        for (int c = 0; c < N_IN; c++) s += int'(hist[c][k]);
        return s;
    endfunction

    function automatic void model_clear();
        for (int c = 0; c < N_IN; c++) wr_n[c] = 0;
        rd_n = 0;
    endfunction

    // One clock: called at a negedge, returns at the next negedge.
    task automatic cycle();
        logic [N_IN-1:0] acc;
        logic            out_x;
        #1;
        acc   = rst ? (bus.in_vld & bus.in_rdy) : '0;
        out_x = rst & bus.sum_vld & bus.sum_rdy;
        if (out_x) begin
            n_out++;
            if (rd_n >= min_wr()) begin
                check("spurious_sum", {31'd0, bus.sum_vld}, 32'd0);
            end else begin
                check("sum_data", {22'd0, bus.sum_data}, exp_sum(rd_n));
                rd_n++;
            end
        end
        for (int c = 0; c < N_IN; c++) begin
            if (acc[c] && wr_n[c] < HMAX) begin
                hist[c][wr_n[c]] = bus.in_data[c*WIDTH +: WIDTH];
                wr_n[c]++;
            end
        end
        last_acc = acc;
        @(posedge clk);
        @(negedge clk);
        bus.in_vld = bus.in_vld & ~acc;
    endtask

    task automatic push_item(input logic [N_IN-1:0] mask, input logic [N_IN*WIDTH-1:0] data);
        for (int c = 0; c < N_IN; c++)
            if (mask[c]) bus.in_data[c*WIDTH +: WIDTH] = data[c*WIDTH +: WIDTH];
        bus.in_vld = bus.in_vld | mask;
        for (int k = 0; k < 50 && (bus.in_vld & mask) != '0; k++) cycle();
        check("push_accepted", {28'd0, bus.in_vld & mask}, 32'd0);
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        bus.in_vld = '0;
        model_clear();
        #1;
        check("rst_in_rdy", {28'd0, bus.in_rdy}, 32'd0);
        check("rst_sum_vld", {31'd0, bus.sum_vld}, 32'd0);
        check("rst_sum_data", {22'd0, bus.sum_data}, 32'd0);
        cycle();
        cycle();
        rst = 1'b1;
        cycle();
        check("post_rst_in_rdy", {28'd0, bus.in_rdy}, 32'hF);
        check("post_rst_sum_vld", {31'd0, bus.sum_vld}, 32'd0);
    endtask

    initial begin
        int base;
        int acc_cnt [N_IN];

        bus.in_vld    = '1;
        bus.in_data   = '0;
        bus.sum_rdy   = 1'b1;
        bus_s.in_vld  = '0;
        bus_s.in_data = '0;
        bus_s.sum_rdy = 1'b1;
        model_clear();
        n_out    = 0;
        last_acc = '0;

        // Reset held with valid asserted
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        check("reset_in_rdy", {28'd0, bus.in_rdy}, 32'd0);
        check("reset_sum_vld", {31'd0, bus.sum_vld}, 32'd0);
        bus.in_vld = '0;
        rst        = 1'b1;
        cycle();
        check("release_in_rdy", {28'd0, bus.in_rdy}, 32'hF);

        // Signed instance
        check("signed_in_rdy", {28'd0, bus_s.in_rdy}, 32'hF);
        bus_s.in_data = {8'h80, 8'h01, 8'hFF, 8'hFF};
        bus_s.in_vld  = '1;
        @(posedge clk);
        @(negedge clk);
        bus_s.in_vld = '0;
        check("signed_latency", {31'd0, bus_s.sum_vld}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        check("signed_vld", {31'd0, bus_s.sum_vld}, 32'd1);
        check("signed_sum", {22'd0, bus_s.sum_data}, 32'h37F);

        // Basic unsigned sum and latency
        push_item(4'hF, {8'd40, 8'd30, 8'd20, 8'd10});
        check("basic_latency", {31'd0, bus.sum_vld}, 32'd0);
        cycle();
        check("basic_vld", {31'd0, bus.sum_vld}, 32'd1);
        check("basic_sum", {22'd0, bus.sum_data}, 32'd100);
        cycle();
        check("basic_drained", {31'd0, bus.sum_vld}, 32'd0);

        // Maximum operands
        push_item(4'hF, {4{8'hFF}});
        cycle();
        check("max_sum", {22'd0, bus.sum_data}, 32'd1020);
        cycle();

        // Skew: channel 0 runs ahead by two items
        base = n_out;
        push_item(4'b0001, {24'd0, 8'h11});
        push_item(4'b0001, {24'd0, 8'h22});
        bus.in_data[7:0] = 8'h33;
        bus.in_vld[0]    = 1'b1;
        cycle();
        cycle();
        check("skew_ch0_rdy", {31'd0, bus.in_rdy[0]}, 32'd0);
        check("skew_no_sum", {31'd0, bus.sum_vld}, 32'd0);
        push_item(4'b1110, {8'h03, 8'h02, 8'h01, 8'h00});
        push_item(4'b1110, {8'h30, 8'h20, 8'h10, 8'h00});
        for (int k = 0; k < 6; k++) cycle();
        check("skew_sum_count", n_out - base, 32'd2);
        do_reset();

        // Backpressure: stream with sum_rdy low until everything stalls
        bus.sum_rdy = 1'b0;
        for (int c = 0; c < N_IN; c++) acc_cnt[c] = 0;
        for (int k = 0; k < 20; k++) begin
            for (int c = 0; c < N_IN; c++) begin
                if (!bus.in_vld[c]) begin
                    bus.in_data[c*WIDTH +: WIDTH] = WIDTH'($urandom);
                    bus.in_vld[c] = 1'b1;
                end
            end
            cycle();
            for (int c = 0; c < N_IN; c++) acc_cnt[c] += int'(last_acc[c]);
        end
        for (int c = 0; c < N_IN; c++) check("bp_accepted", acc_cnt[c], OUT_DEPTH + 2);
        check("bp_in_rdy", {28'd0, bus.in_rdy}, 32'd0);
        check("bp_sum_vld", {31'd0, bus.sum_vld}, 32'd1);
        base        = n_out;
        bus.sum_rdy = 1'b1;
        for (int k = 0; k < 30; k++) cycle();
        check("bp_delivered", n_out - base, OUT_DEPTH + 3);
        check("bp_model_empty", min_wr() - rd_n, 32'd0);
        check("bp_sum_vld_end", {31'd0, bus.sum_vld}, 32'd0);

        // Random traffic with a reset in the middle
        for (int k = 0; k < 10000; k++) begin
            if (k == 5000) begin
                do_reset();
                for (int j = 0; j < 3; j++) begin
                    cycle();
                    check("no_stale_sum", {31'd0, bus.sum_vld}, 32'd0);
                end
            end
            for (int c = 0; c < N_IN; c++) begin
                if (!bus.in_vld[c] && ($urandom % 4) != 0) begin
                    bus.in_data[c*WIDTH +: WIDTH] =
                        (($urandom % 8) == 0) ? {WIDTH{1'b1}} : WIDTH'($urandom);
                    bus.in_vld[c] = 1'b1;
                end
            end
            bus.sum_rdy = (($urandom % 3) != 0);
            cycle();
        end

        // Drain whatever was matched across all channels
        bus.sum_rdy = 1'b1;
        for (int k = 0; k < 40; k++) cycle();
        check("final_model_empty", min_wr() - rd_n, 32'd0);
        check("final_sum_vld", {31'd0, bus.sum_vld}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
